// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: state encoding and parameter defaults shared by mem_access_ctrl and mem_bus_drv
// Optional feature macro: MEM_WRPROT_EN adds the CHECK state used for protected stores.
package mem_access_ctrl_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam logic [7:0] PROT_BASE_DEF = 8'hFE;
`ifdef MEM_WRPROT_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_RESP  = 3'd3,
    ST_CHECK = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;
`endif
endpackage

// File: rtl/mem_access_ctrl_bus_drv.sv
// mem_bus_drv: tristate driver for the shared memory data bus plus the read-data capture register
// Ports: clk, rst_n (sync active-low), oe (drive bus with wdata), cap_en (capture bus),
//        clr (zero the capture register), wdata, bus (inout), rdata (captured value).
module mem_bus_drv
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              oe,
  input  logic              cap_en,
  input  logic              clr,
  input  logic [DATA_W-1:0] wdata,
  inout  wire  [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] rdata_q, rdata_d;
  assign bus = oe ? wdata : 'z;
  assign rdata = rdata_q;
  always_comb rdata_d = clr ? '0 : cap_en ? bus : rdata_q;
  always_ff @(posedge clk) rdata_q <= !rst_n ? '0 : rdata_d;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store front end for a 256x8 data memory
// Ports: clk, rst_n (sync active-low); req_* valid/ready request channel (we, addr, wdata);
//        rsp_* valid/ready response channel (rdata, err); mem_addr/mem_we/mem_re/mem_data to the
//        memory; busy while not IDLE. Optional macro MEM_WRPROT_EN rejects stores at addr >= PROT_BASE.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] PROT_BASE = ADDR_W'(PROT_BASE_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              mem_re,
  output logic              busy
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic err_q, err_d;
  logic prot, oe, cap_en, clr;
`ifdef MEM_WRPROT_EN
  assign prot = req_we && req_addr >= PROT_BASE;
`else
  logic unused_prot_base;
  assign unused_prot_base = ^PROT_BASE;
  assign prot = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        addr_d  = req_addr;
        wdata_d = req_wdata;
        err_d   = prot;
`ifdef MEM_WRPROT_EN
        state_d = prot ? ST_CHECK : req_we ? ST_WRITE : ST_READ;
`else
        state_d = req_we ? ST_WRITE : ST_READ;
`endif
      end
      ST_WRITE, ST_READ: state_d = ST_RESP;
`ifdef MEM_WRPROT_EN
      ST_CHECK: state_d = ST_RESP;
`endif
      ST_RESP: state_d = rsp_ready ? ST_IDLE : ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end
  // memory-side controls come only from registered state so req_* never reaches mem_* combinationally
  always_comb begin
    req_ready = state_q == ST_IDLE;
    busy      = state_q != ST_IDLE;
    rsp_valid = state_q == ST_RESP;
    rsp_err   = err_q;
    mem_addr  = addr_q;
    mem_we    = state_q == ST_WRITE;
    mem_re    = state_q == ST_READ;
    oe        = state_q == ST_WRITE;
    cap_en    = state_q == ST_READ;
    clr       = state_q == ST_IDLE && req_valid && req_we;
  end
  mem_bus_drv #(.DATA_W(DATA_W)) u_bus (
    .clk    (clk),
    .rst_n  (rst_n),
    .oe     (oe),
    .cap_en (cap_en),
    .clr    (clr),
    .wdata  (wdata_q),
    .bus    (mem_data),
    .rdata  (rsp_rdata)
  );
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed table-driven bench for mem_access_ctrl with a 256x8 memory model
module tb_mem_access_ctrl;
`ifdef MEM_WRPROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err, mem_we, mem_re, busy;
  logic [7:0] rsp_rdata, mem_addr;
  wire  [7:0] mem_data;
  logic [7:0] mem [256];
  int n_chk = 0, n_fail = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // memory drives on read; the bench holds the idle bus at 0 so a stray controller drive shows up
  assign mem_data = mem_re ? mem[mem_addr] : (mem_we ? 'z : 8'h00);
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_data;
  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_re(mem_re), .busy(busy)
  );
  typedef struct {
    logic       we;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] er;
    logic       ee;
    int         wp;
  } vec_t;
  vec_t v[10];
  logic [7:0] bb_a [4];
  logic [7:0] bb_d [4];
  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_idle(input string nm);
    chk(req_ready, 1, {nm, "_req_ready"});
    chk(rsp_valid, 0, {nm, "_rsp_valid"});
    chk(rsp_rdata, 0, {nm, "_rsp_rdata"});
    chk(rsp_err, 0, {nm, "_rsp_err"});
    chk(mem_addr, 0, {nm, "_mem_addr"});
    chk(mem_we, 0, {nm, "_mem_we"});
    chk(mem_re, 0, {nm, "_mem_re"});
    chk(busy, 0, {nm, "_busy"});
    chk(mem_data, 8'h00, {nm, "_bus_released"});
  endtask
  task automatic txn(input vec_t t, input string nm);
    int lat, n_we;
    @(negedge clk);
    chk(req_ready, 1, {nm, "_ready"});
    req_valid = 1'b1; req_we = t.we; req_addr = t.a; req_wdata = t.d; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; n_we = 0;
    while (!rsp_valid && lat < 8) begin
      chk(req_ready, 0, {nm, "_ready_busy"});
      if (mem_we) begin
        n_we++;
        chk(mem_addr, t.a, {nm, "_wr_addr"});
        chk(mem_data, t.d, {nm, "_wr_data"});
      end
      if (mem_re) begin
        chk(mem_we, 0, {nm, "_rd_we"});
        chk(mem_addr, t.a, {nm, "_rd_addr"});
        chk(mem_data, t.er, {nm, "_rd_bus"});
      end
      @(posedge clk); #1;
      lat++;
    end
    chk(lat, 2, {nm, "_latency"});
    chk(n_we, t.wp, {nm, "_we_pulses"});
    chk(rsp_rdata, t.er, {nm, "_rdata"});
    chk(rsp_err, t.ee, {nm, "_err"});
    chk(mem_data, 8'h00, {nm, "_resp_bus"});
    @(posedge clk); #1;
    chk(rsp_valid, 0, {nm, "_rsp_drop"});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int k_acc, k_we, last_acc, last_we;
    foreach (mem[i]) mem[i] = 8'h00;
    mem[8'hFF] = 8'h03;
    mem[8'hFE] = 8'h2A;
    v[0] = '{1'b1, 8'h10, 8'h5A, 8'h00, 1'b0, 1};
    v[1] = '{1'b0, 8'h10, 8'h00, 8'h5A, 1'b0, 0};
    v[2] = '{1'b0, 8'hFF, 8'h00, 8'h03, 1'b0, 0};
    v[3] = '{1'b0, 8'hFE, 8'h00, 8'h2A, 1'b0, 0};
    v[4] = '{1'b1, 8'hFE, 8'h77, 8'h00, PROT, PROT ? 0 : 1};
    v[5] = '{1'b0, 8'hFE, 8'h00, PROT ? 8'h2A : 8'h77, 1'b0, 0};
    v[6] = '{1'b1, 8'h00, 8'hC3, 8'h00, 1'b0, 1};
    v[7] = '{1'b0, 8'h00, 8'h00, 8'hC3, 1'b0, 0};
    v[8] = '{1'b1, 8'hFD, 8'h81, 8'h00, 1'b0, 1};
    v[9] = '{1'b0, 8'hFD, 8'h00, 8'h81, 1'b0, 0};
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) txn(v[i], $sformatf("vec%0d", i));
    // response backpressure with a second request waiting
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hFF;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 8'h20; req_wdata = 8'h99;
    for (int i = 0; i < 8 && !rsp_valid; i++) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk(rsp_valid, 1, "bp_valid");
      chk(rsp_rdata, 8'h03, "bp_rdata");
      chk(req_ready, 0, "bp_req_ready");
      chk(mem_we, 0, "bp_no_write");
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk(rsp_valid, 0, "bp_drop");
    chk(req_ready, 1, "bp_idle");
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk(mem_we, 1, "bp_second_we");
    chk(mem_addr, 8'h20, "bp_second_addr");
    @(posedge clk); #1;
    chk(rsp_valid, 1, "bp_second_valid");
    chk(rsp_rdata, 8'h00, "bp_second_rdata");
    @(posedge clk); #1;
    // back-to-back stores with req_valid held high
    bb_a = '{8'h40, 8'h41, 8'h42, 8'h43};
    bb_d = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    k_acc = 0; k_we = 0; last_acc = 0; last_we = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = bb_a[0]; req_wdata = bb_d[0];
    for (int c = 0; c < 40 && k_we < 4; c++) begin
      if (mem_we) begin
        chk(mem_addr, bb_a[k_we], "bb_addr");
        chk(mem_data, bb_d[k_we], "bb_data");
        if (k_we > 0) chk(cyc - last_we, 3, "bb_we_gap");
        last_we = cyc; k_we++;
      end
      if (req_ready && req_valid) begin
        if (k_acc > 0) chk(cyc - last_acc, 3, "bb_accept_gap");
        last_acc = cyc; k_acc++;
        @(posedge clk); #1;
        if (k_acc < 4) begin
          req_addr = bb_a[k_acc]; req_wdata = bb_d[k_acc];
        end else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk(k_we, 4, "bb_we_count");
    chk(k_acc, 4, "bb_accept_count");
    repeat (3) @(negedge clk);
    txn('{1'b0, 8'h41, 8'h00, 8'hA2, 1'b0, 0}, "bb_rd1");
    txn('{1'b0, 8'h43, 8'h00, 8'hA4, 1'b0, 0}, "bb_rd3");
    // reset on the edge that closes READ
    @(negedge clk);
    rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk(mem_re, 1, "mr_in_read");
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_idle("mid_read_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store front end that sits directly upstream of the 256x8 data memory. It owns the memory's address, write-enable and read-enable lines, and the shared bidirectional data bus.
- Accepts one load or store at a time from the CPU datapath over a valid/ready handshake. Sequences the memory bus with no drive contention and returns read data or write completion over a valid/ready response channel.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, data bus width.
- PROT_BASE, 8'hFE, lowest write-protected address. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  datapath takes the response.
- rsp_rdata  out  DATA_W  load data; 0 for stores.
- rsp_err  out  1  request rejected (protected store).
- mem_addr  out  ADDR_W  to memory Address.
- mem_data  inout  DATA_W  to memory Databus.
- mem_we  out  1  to memory Write_en.
- mem_re  out  1  to memory Read_en.
- busy  out  1  state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled only on the rising edge of clk.
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; mem_addr=0; mem_we=0; mem_re=0; mem_data=Z; busy=0.
- State machine: IDLE, WRITE, READ, RESP. mem_we, mem_re, mem_addr and the mem_data drive enable are decoded from registered state only. No combinational path runs from req_* to mem_*.
- IDLE:
  - req_ready=1.
  - On req_valid at a rising edge, latch req_addr, req_we and req_wdata.
  - Go to WRITE if req_we=1, else READ.
- WRITE (1 cycle): mem_addr=latched addr, mem_data driven with latched wdata, mem_we=1, mem_re=0. The memory writes at the closing edge. Go to RESP.
- READ (1 cycle): mem_addr=latched addr, mem_re=1, mem_we=0, mem_data=Z. Capture mem_data into rsp_rdata at the closing edge. Go to RESP.
- RESP:
  - rsp_valid=1. mem_we=mem_re=0 and mem_data=Z.
  - rsp_valid, rsp_rdata and rsp_err hold stable until rsp_valid&&rsp_ready at a rising edge.
  - On that handshake go to IDLE; rsp_valid falls the next cycle.
- Latency: accept edge to rsp_valid is 2 edges for both loads and stores. Minimum issue interval is 3 cycles when rsp_ready is held high.
- Bus safety: the controller drives mem_data only in WRITE and mem_re is high only in READ, so drive and read never overlap. Each access is separated from the next by RESP and IDLE, which gives at least one turnaround cycle.
- req_ready=0 in every state except IDLE. req_valid outside IDLE is ignored and the request is not consumed.
- rsp_rdata is cleared to 0 when a store is accepted.
- Reset mid-operation: rst_n low at an edge forces IDLE and the reset values. A write whose WRITE cycle closes on that same edge does complete in memory, because mem_we was already high during that cycle. The pending response is discarded.
- Address wraps naturally at 8 bits; there is no range checking beyond the optional feature.

Optional Feature:
- Macro: MEM_WRPROT_EN.
- Defined:
  - A store with addr >= PROT_BASE skips WRITE and goes IDLE to RESP after a 1-cycle internal check state.
  - Latency stays 2 edges. mem_we is never asserted for that store, rsp_err=1 in RESP and memory is unchanged.
  - Loads are never blocked.
- Undefined: rsp_err is tied to 0 and all stores proceed.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, WRITE=2'd1, READ=2'd2, RESP=2'd3, plus CHECK when the feature is enabled);
  - ADDR_W and DATA_W defaults;
  - the PROT_BASE default.
- One natural sub-module, mem_bus_drv: the tristate driver (mem_data = oe ? wdata : Z) plus the capture register. This isolates the inout from the FSM.

Test Plan:
- Store then load: store 8'h5A to 8'h10, then load 8'h10 with rsp_ready=1. Required: mem_we high exactly 1 cycle with mem_addr=8'h10; the load returns rsp_rdata=8'h5A 2 edges after accept.
- Load of preset constants: load 8'hFF and 8'hFE. Required: rsp_rdata=8'h03 and 8'h2A; mem_data is never driven by the controller during READ.
- Response backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid. Required: rsp_valid and rsp_rdata stay stable, req_ready=0, and a second req_valid is not accepted until the handshake.
- Reset mid-read: assert rst_n=0 on the edge closing READ. Required: next cycle state is IDLE, rsp_valid=0, mem_re=0, mem_data=Z, req_ready=1.
- Back-to-back with rsp_ready=1: req_valid held high for 4 stores. Required: exactly one accept every 3 cycles, no two mem_we pulses closer than 3 cycles, no contention (X) on mem_data.
- With MEM_WRPROT_EN: store 8'h77 to 8'hFE. Required: mem_we stays 0, rsp_err=1, and a following load of 8'hFE returns 8'h2A. Without the macro, the same store writes 8'h77 and rsp_err=0.
